// File: rtl/intersection_phase_scheduler_if.sv
// Signal bundle between the intersection phase scheduler and its environment.
interface intersection_phase_scheduler_if;
  logic       ns_car;
  logic       ew_car;
  logic       ped_req;
  logic       emerg;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;
  logic       dir;

  // Environment side: drives demand/preempt, observes the heads
  modport master (
    output ns_car, ew_car, ped_req, emerg,
    input  ns_light, ew_light, walk, ped_pending, phase, dir
  );

  // Scheduler side
  modport slave (
    input  ns_car, ew_car, ped_req, emerg,
    output ns_light, ew_light, walk, ped_pending, phase, dir
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase scheduler: green/yellow/clearance sequencing,
// demand-driven green length, pedestrian walk insertion, emergency preemption.
module intersection_phase_scheduler #(
  parameter int unsigned TW        = 8,
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 12,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned CLEAR_T   = 1,
  parameter int unsigned WALK_T    = 5
) (
  input  logic clk,
  input  logic rst,
  intersection_phase_scheduler_if.slave bus
);

  localparam logic [2:0] ST_GREEN   = 3'd0;
  localparam logic [2:0] ST_YELLOW  = 3'd1;
  localparam logic [2:0] ST_CLEAR   = 3'd2;
  localparam logic [2:0] ST_WALK    = 3'd3;
  localparam logic [2:0] ST_PREEMPT = 3'd4;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  // Timers load DUR-1 so a state lasts exactly DUR cycles
  localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] CLEAR_LD  = TW'(CLEAR_T - 1);
  localparam logic [TW-1:0] WALK_LD   = TW'(WALK_T - 1);
  localparam logic [TW-1:0] MIN_G     = TW'(MIN_GREEN);
  localparam logic [TW-1:0] MAX_G     = TW'(MAX_GREEN);

  logic [2:0]    state_q, state_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] elapsed_q, elapsed_d;
  logic          ped_q, ped_d;
  logic [2:0]    ns_light_q, ns_light_d;
  logic [2:0]    ew_light_q, ew_light_d;
  logic          walk_q, walk_d;
  logic          opp_car;
  logic          timer_done;

  assign opp_car    = dir_q ? bus.ns_car : bus.ew_car;
  assign timer_done = (timer_q == '0);

  // Next-state, timers, pedestrian latch and head decode of the next state
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    timer_d   = timer_done ? timer_q : timer_q - TW'(1);
    elapsed_d = elapsed_q;

    case (state_q)
      ST_GREEN: begin
        elapsed_d = elapsed_q + TW'(1);
        if (bus.emerg || elapsed_q == MAX_G ||
            (elapsed_q >= MIN_G && (opp_car || ped_q))) begin
          state_d = ST_YELLOW;
          timer_d = YELLOW_LD;
        end
      end
      ST_YELLOW: begin
        // Yellow always runs to completion, even under preemption
        if (timer_done) begin
          if (bus.emerg) begin
            state_d = ST_PREEMPT;
          end else begin
            state_d = ST_CLEAR;
            dir_d   = ~dir_q;
            timer_d = CLEAR_LD;
          end
        end
      end
      ST_CLEAR: begin
        if (bus.emerg) begin
          state_d = ST_PREEMPT;
        end else if (timer_done) begin
          if (ped_q) begin
            state_d = ST_WALK;
            timer_d = WALK_LD;
          end else begin
            state_d   = ST_GREEN;
            elapsed_d = TW'(1);
          end
        end
      end
      ST_WALK: begin
        if (bus.emerg) begin
          state_d = ST_PREEMPT;
        end else if (timer_done) begin
          state_d   = ST_GREEN;
          elapsed_d = TW'(1);
        end
      end
      ST_PREEMPT: begin
        if (!bus.emerg) begin
          state_d = ST_CLEAR;
          dir_d   = 1'b0;
          timer_d = CLEAR_LD;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        dir_d   = 1'b0;
        timer_d = CLEAR_LD;
      end
    endcase

    ped_d = (ped_q | bus.ped_req) & (state_d != ST_WALK);

    ns_light_d = L_RED;
    ew_light_d = L_RED;
    walk_d     = 1'b0;
    case (state_d)
      ST_GREEN: begin
        if (dir_d) ew_light_d = L_GRN;
        else       ns_light_d = L_GRN;
      end
      ST_YELLOW: begin
        if (dir_d) ew_light_d = L_YEL;
        else       ns_light_d = L_YEL;
      end
      ST_WALK: walk_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; lights change on the same edge as state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      dir_q      <= 1'b0;
      timer_q    <= CLEAR_LD;
      elapsed_q  <= '0;
      ped_q      <= 1'b0;
      ns_light_q <= L_RED;
      ew_light_q <= L_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      timer_q    <= timer_d;
      elapsed_q  <= elapsed_d;
      ped_q      <= ped_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      walk_q     <= walk_d;
    end
  end

  assign bus.ns_light    = ns_light_q;
  assign bus.ew_light    = ew_light_q;
  assign bus.walk        = walk_q;
  assign bus.ped_pending = ped_q;
  assign bus.phase       = state_q;
  assign bus.dir         = dir_q;

  // Conflicting greens and walk over live traffic must never appear
  a_heads_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ns_light_q != L_RED && ew_light_q != L_RED));
  a_walk_all_red: assert property (@(posedge clk) disable iff (rst)
    !(walk_q && (ns_light_q != L_RED || ew_light_q != L_RED)));

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed, table-driven bench for intersection_phase_scheduler.
module tb_intersection_phase_scheduler;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  // Input nibble order: {ns_car, ew_car, ped_req, emerg}
  localparam logic [3:0] I_NONE = 4'b0000;
  localparam logic [3:0] I_EW   = 4'b0100;
  localparam logic [3:0] I_BOTH = 4'b1100;
  localparam logic [3:0] I_PED  = 4'b0010;
  localparam logic [3:0] I_EM   = 4'b0001;

  typedef struct {
    bit          rst_before;
    int          cnt;
    logic [3:0]  in;
    logic [11:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  vec_t tbl[$];

  intersection_phase_scheduler_if bus ();

  intersection_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs {ns, ew, walk, ped_pending, phase, dir}
  function automatic logic [11:0] pk(input logic [2:0] ns, input logic [2:0] ew,
                                     input logic w, input logic p,
                                     input logic [2:0] ph, input logic d);
    return {ns, ew, w, p, ph, d};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.ns_light, bus.ew_light, bus.walk, bus.ped_pending, bus.phase, bus.dir};
  endfunction

  task automatic add(input bit r, input int n, input logic [3:0] in,
                     input logic [2:0] ns, input logic [2:0] ew, input logic w,
                     input logic p, input logic [2:0] ph, input logic d);
    vec_t v;
    v.rst_before = r;
    v.cnt        = n;
    v.in         = in;
    v.exp        = pk(ns, ew, w, p, ph, d);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got ns=%b ew=%b walk=%b ped=%b phase=%0d dir=%b, want ns=%b ew=%b walk=%b ped=%b phase=%0d dir=%b",
               name, got[11:9], got[8:6], got[5], got[4], got[3:1], got[0],
               exp[11:9], exp[8:6], exp[5], exp[4], exp[3:1], exp[0]);
    end
  endtask

  task automatic drive(input logic [3:0] in);
    bus.ns_car  = in[3];
    bus.ew_car  = in[2];
    bus.ped_req = in[1];
    bus.emerg   = in[0];
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    drive(I_NONE);
    @(posedge clk);
    #1;
    check(name, obs(), pk(R, R, 1'b0, 1'b0, 3'd2, 1'b0));
    rst = 1'b0;
  endtask

  // Safety: never two live heads, never walk over a live head
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_cmp++;
      if ((bus.ns_light != R && bus.ew_light != R) ||
          (bus.walk && (bus.ns_light != R || bus.ew_light != R))) begin
        n_bad++;
        $display("FAIL safety: ns=%b ew=%b walk=%b, want at most one non-red head and all red during walk",
                 bus.ns_light, bus.ew_light, bus.walk);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(I_NONE);

    // No demand: fair alternation at MAX_GREEN
    add(1, 12, I_NONE, G, R, 0, 0, 3'd0, 0);
    add(0,  2, I_NONE, Y, R, 0, 0, 3'd1, 0);
    add(0,  1, I_NONE, R, R, 0, 0, 3'd2, 1);
    add(0, 12, I_NONE, R, G, 0, 0, 3'd0, 1);
    add(0,  2, I_NONE, R, Y, 0, 0, 3'd1, 1);
    add(0,  1, I_NONE, R, R, 0, 0, 3'd2, 0);
    add(0,  2, I_NONE, G, R, 0, 0, 3'd0, 0);

    // EW demand only: NS green cut to MIN_GREEN, EW green runs to MAX_GREEN
    add(1,  4, I_EW, G, R, 0, 0, 3'd0, 0);
    add(0,  2, I_EW, Y, R, 0, 0, 3'd1, 0);
    add(0,  1, I_EW, R, R, 0, 0, 3'd2, 1);
    add(0, 12, I_EW, R, G, 0, 0, 3'd0, 1);
    add(0,  1, I_EW, R, Y, 0, 0, 3'd1, 1);

    // Demand on both roads: both greens at MIN_GREEN
    add(1, 4, I_BOTH, G, R, 0, 0, 3'd0, 0);
    add(0, 2, I_BOTH, Y, R, 0, 0, 3'd1, 0);
    add(0, 1, I_BOTH, R, R, 0, 0, 3'd2, 1);
    add(0, 4, I_BOTH, R, G, 0, 0, 3'd0, 1);
    add(0, 2, I_BOTH, R, Y, 0, 0, 3'd1, 1);
    add(0, 1, I_BOTH, R, R, 0, 0, 3'd2, 0);
    add(0, 1, I_BOTH, G, R, 0, 0, 3'd0, 0);

    // Ped pulse in NS green cycle 2; requests during walk are dropped
    add(1, 2, I_NONE, G, R, 0, 0, 3'd0, 0);
    add(0, 1, I_PED,  G, R, 0, 1, 3'd0, 0);
    add(0, 1, I_NONE, G, R, 0, 1, 3'd0, 0);
    add(0, 2, I_NONE, Y, R, 0, 1, 3'd1, 0);
    add(0, 1, I_NONE, R, R, 0, 1, 3'd2, 1);
    add(0, 5, I_PED,  R, R, 1, 0, 3'd3, 1);
    add(0, 1, I_NONE, R, G, 0, 0, 3'd0, 1);

    // Emergency from NS green cycle 2 for 6 cycles
    add(1, 2, I_NONE, G, R, 0, 0, 3'd0, 0);
    add(0, 2, I_EM,   Y, R, 0, 0, 3'd1, 0);
    add(0, 4, I_EM,   R, R, 0, 0, 3'd4, 0);
    add(0, 1, I_NONE, R, R, 0, 0, 3'd2, 0);
    add(0, 1, I_NONE, G, R, 0, 0, 3'd0, 0);

    // Emergency pulse in walk cycle 3
    add(1, 2, I_NONE, G, R, 0, 0, 3'd0, 0);
    add(0, 1, I_PED,  G, R, 0, 1, 3'd0, 0);
    add(0, 1, I_NONE, G, R, 0, 1, 3'd0, 0);
    add(0, 2, I_NONE, Y, R, 0, 1, 3'd1, 0);
    add(0, 1, I_NONE, R, R, 0, 1, 3'd2, 1);
    add(0, 3, I_NONE, R, R, 1, 0, 3'd3, 1);
    add(0, 1, I_EM,   R, R, 0, 0, 3'd4, 1);
    add(0, 1, I_NONE, R, R, 0, 0, 3'd2, 0);
    add(0, 1, I_NONE, G, R, 0, 0, 3'd0, 0);

    // Emergency in CLEAR's last cycle beats pending ped; ped survives preempt
    add(1, 2, I_NONE, G, R, 0, 0, 3'd0, 0);
    add(0, 1, I_PED,  G, R, 0, 1, 3'd0, 0);
    add(0, 1, I_NONE, G, R, 0, 1, 3'd0, 0);
    add(0, 2, I_NONE, Y, R, 0, 1, 3'd1, 0);
    add(0, 1, I_NONE, R, R, 0, 1, 3'd2, 1);
    add(0, 1, I_EM,   R, R, 0, 1, 3'd4, 1);
    add(0, 1, I_NONE, R, R, 0, 1, 3'd2, 0);
    add(0, 1, I_NONE, R, R, 1, 0, 3'd3, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset($sformatf("reset_v%0d", i));
      for (int k = 0; k < tbl[i].cnt; k++) begin
        drive(tbl[i].in);
        @(posedge clk);
        #1;
        check($sformatf("v%0d.%0d", i, k), obs(), tbl[i].exp);
      end
    end

    // Asynchronous reset during EW yellow cycle 1
    do_reset("reset_async_seq");
    drive(I_BOTH);
    repeat (12) @(posedge clk);
    #1;
    check("ew_yellow1", obs(), pk(R, Y, 1'b0, 1'b0, 3'd1, 1'b1));
    rst = 1'b1;
    #1;
    check("async_rst", obs(), pk(R, R, 1'b0, 1'b0, 3'd2, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(I_NONE);
    check("post_rst_clear", obs(), pk(R, R, 1'b0, 1'b0, 3'd2, 1'b0));
    @(posedge clk);
    #1;
    check("post_rst_green", obs(), pk(G, R, 1'b0, 1'b0, 3'd0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
